// File: rtl/scramble_cipher_p.sv
// Symbol scrambler: a small multi-cycle FSM that seeds, mixes, range-reduces
// and offsets each accepted symbol before emitting its magnitude.
module scramble_cipher_p #(
  parameter int W    = 6,
  parameter int LIM  = 26,
  parameter int CMAX = 25
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         stbi,
  input  logic         mode,
  output logic [W-1:0] x_out,
  output logic         out_vld,
  output logic         busy
);

  localparam int AW = W + 3;
  localparam logic signed [AW-1:0] LIM_S     = AW'(LIM);
  localparam logic signed [AW-1:0] NEG_LIM_S = -LIM_S;
  localparam logic [W-1:0]         LIM_U     = W'(LIM);
  localparam logic [W-1:0]         CMAX_U    = W'(CMAX);

  typedef enum logic [3:0] {
    IDLE, WAIT, CHECK, SEED, MIX, RED_DN, RED_UP, OFFS, EMIT
  } state_t;

  state_t                 state, state_nxt;
  logic [W-1:0]           r_in, r_in_nxt;
  logic [W-1:0]           cont, cont_nxt;
  logic signed [AW-1:0]   acc, acc_nxt;
  logic signed [AW-1:0]   offset;
  logic [W-1:0]           acc_lo;
  logic [W-1:0]           x_out_nxt;
  logic                   out_vld_nxt;

  assign busy   = (state != IDLE) && (state != WAIT);
  assign acc_lo = acc[W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      r_in    <= '0;
      cont    <= '0;
      acc     <= '0;
      x_out   <= '0;
      out_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      r_in    <= r_in_nxt;
      cont    <= cont_nxt;
      acc     <= acc_nxt;
      x_out   <= x_out_nxt;
      out_vld <= out_vld_nxt;
    end
  end

  // All-zeros and all-ones symbols bypass the cipher but still advance cont.
  always_comb begin
    state_nxt   = state;
    r_in_nxt    = r_in;
    cont_nxt    = cont;
    acc_nxt     = acc;
    x_out_nxt   = x_out;
    out_vld_nxt = 1'b0;
    offset      = '0;
    case (state)
      IDLE: begin
        cont_nxt  = '0;
        r_in_nxt  = x_in;
        state_nxt = WAIT;
      end
      WAIT: begin
        r_in_nxt = x_in;
        if (!stbi) state_nxt = CHECK;
      end
      CHECK: begin
        if (r_in == '0 || r_in == '1) begin
          cont_nxt  = (cont < CMAX_U) ? cont + W'(1) : '0;
          acc_nxt   = {3'b000, r_in};
          state_nxt = EMIT;
        end else if (r_in <= LIM_U) begin
          state_nxt = SEED;
        end else begin
          state_nxt = WAIT;
        end
      end
      SEED: begin
        acc_nxt   = r_in[0] ? {2'b00, cont, 1'b0} : {3'b000, cont};
        state_nxt = MIX;
      end
      MIX: begin
        if (r_in[1]) begin
          acc_nxt   = {3'b000, r_in} + acc;
          state_nxt = RED_DN;
        end else begin
          acc_nxt   = {3'b000, r_in} - acc;
          state_nxt = RED_UP;
        end
      end
      RED_DN: begin
        if (acc > LIM_S) acc_nxt = acc - LIM_S;
        else             state_nxt = OFFS;
      end
      RED_UP: begin
        if (acc < NEG_LIM_S) acc_nxt = acc + LIM_S;
        else                 state_nxt = OFFS;
      end
      OFFS: begin
        case (r_in[3:2])
          2'b00:   offset = AW'(-21);
          2'b01:   offset = AW'(-42);
          2'b10:   offset = AW'(7);
          default: offset = AW'(28);
        endcase
        if (mode) offset = -offset;
        acc_nxt   = acc + offset;
        state_nxt = EMIT;
      end
      EMIT: begin
        // Low bits of -acc equal the negation of acc's low bits modulo 2^W.
        x_out_nxt   = acc[AW-1] ? -acc_lo : acc_lo;
        out_vld_nxt = 1'b1;
        state_nxt   = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
